// File: rtl/rsb_ret_pkg.sv
// Shared definitions for the return-stack-buffer return checker.
// Holds the default address MSB, RSB depth, stomp-count width, the FSM
// state encoding and a saturating helper for the stomp count.
package rsb_ret_pkg;

  localparam int RSB_AMSB  = 79;
  localparam int RSB_DEPTH = 8;
  localparam int STOMP_W   = 3;

  // Largest value representable on the stompedRets port.
  localparam logic [7:0] STOMP_MAX = 8'd7;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } rsb_state_e;

  // Saturate a small entry count to the stomp-count width.
  function automatic logic [STOMP_W-1:0] sat_stomp(input logic [7:0] n);
    logic [STOMP_W-1:0] r;
    if (n > STOMP_MAX) begin
      r = STOMP_MAX[STOMP_W-1:0];
    end else begin
      r = n[STOMP_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/rsb_ret_fifo.sv
// Circular FIFO of predicted return addresses.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   i_push/i_push_data write entry at tail (dropped when full)
//   i_pop             discard head entry (ignored when empty)
//   i_clear           empty the FIFO; overrides push and pop
//   o_head_data       oldest entry (combinational read)
//   o_count/o_full/o_empty  registered occupancy
module rsb_ret_fifo
  import rsb_ret_pkg::*;
#(
  parameter int AMSB  = RSB_AMSB,
  parameter int DEPTH = RSB_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [AMSB:0]              i_push_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic [AMSB:0]              o_head_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

  logic [AMSB:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_empty;
  logic            w_push_ok;
  logic            w_pop_ok;
  logic [CW-1:0]   w_count_nxt;

  assign w_push_ok = i_push & ~r_full  & ~i_clear;
  assign w_pop_ok  = i_pop  & ~r_empty & ~i_clear;

  // Next occupancy from accepted push/pop, clear takes priority.
  always_comb begin
    w_count_nxt = r_count;
    if (i_clear) begin
      w_count_nxt = '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   w_count_nxt = r_count + CNT_ONE;
        2'b01:   w_count_nxt = r_count - CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer, count and flag registers; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (i_clear) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push_ok) r_tail <= r_tail + PTR_ONE;
        if (w_pop_ok)  r_head <= r_head + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_tail] <= i_push_data;
    end
  end

  assign o_head_data = r_mem[r_head];
  assign o_count     = r_count;
  assign o_full      = r_full;
  assign o_empty     = r_empty;

endmodule

// File: rtl/rsb_ret_checker.sv
// Checks RSB-predicted return addresses against resolved targets.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   push_v/push_ra           queue an RSB-predicted return address
//   res_v/res_target         oldest return resolved with its real target
//   flush                    older-branch flush, discards all predictions
//   full/empty/count         registered FIFO occupancy
//   mispredict/correct_ip    one-cycle redirect on a wrong prediction
//   stompedRets/stompedRet   discarded younger predictions (to the RSB)
//   overflow                 sticky: push attempted while full
module rsb_ret_checker
  import rsb_ret_pkg::*;
#(
  parameter int AMSB  = RSB_AMSB,
  parameter int DEPTH = RSB_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_v,
  input  logic [AMSB:0]          push_ra,
  input  logic                   res_v,
  input  logic [AMSB:0]          res_target,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   mispredict,
  output logic [AMSB:0]          correct_ip,
  output logic [STOMP_W-1:0]     stompedRets,
  output logic                   stompedRet,
  output logic                   overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  rsb_state_e          r_state;
  rsb_state_e          w_state_nxt;
  logic [AMSB:0]       w_head_data;
  logic [CW-1:0]       w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_run;
  logic                w_res_act;
  logic                w_mis;
  logic                w_push;
  logic                w_pop;
  logic                w_clear;
  logic [STOMP_W-1:0]  w_stomp_nxt;

  logic                r_mispredict;
  logic [AMSB:0]       r_correct_ip;
  logic [STOMP_W-1:0]  r_stomped;
  logic                r_stomped_any;
  logic                r_overflow;

  assign w_run     = (r_state == ST_RUN);
  // Flush outranks resolve and push; RECOVER ignores both.
  assign w_res_act = w_run & res_v & ~w_empty & ~flush;
  assign w_mis     = w_res_act & (res_target != w_head_data);
  // A push in the same cycle as a mismatch belongs to the wrong path.
  assign w_push    = w_run & push_v & ~flush & ~w_mis;
  assign w_pop     = w_res_act & ~w_mis;
  assign w_clear   = flush | w_mis;

  rsb_ret_fifo #(
    .AMSB  (AMSB),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (push_ra),
    .i_pop       (w_pop),
    .i_clear     (w_clear),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  // Number of younger predictions thrown away by a flush or mismatch.
  // On mismatch the head itself is consumed, hence the minus one.
  always_comb begin
    w_stomp_nxt = '0;
    if (flush) begin
      w_stomp_nxt = sat_stomp(8'(w_count) + 8'(push_v));
    end else if (w_mis) begin
      w_stomp_nxt = sat_stomp(8'(w_count) - 8'd1 + 8'(push_v));
    end else begin
      w_stomp_nxt = '0;
    end
  end

  // Next-state logic: a mismatch costs exactly one RECOVER cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (flush) begin
          w_state_nxt = ST_RUN;
        end else if (w_mis) begin
          w_state_nxt = ST_RECOVER;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RECOVER: w_state_nxt = ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered redirect, stomp report and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mispredict  <= 1'b0;
      r_correct_ip  <= '0;
      r_stomped     <= '0;
      r_stomped_any <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_mispredict  <= w_mis;
      if (w_mis) begin
        r_correct_ip <= res_target;
      end
      r_stomped     <= w_stomp_nxt;
      r_stomped_any <= (w_stomp_nxt != '0);
      if (push_v && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign full        = w_full;
  assign empty       = w_empty;
  assign count       = w_count;
  assign mispredict  = r_mispredict;
  assign correct_ip  = r_correct_ip;
  assign stompedRets = r_stomped;
  assign stompedRet  = r_stomped_any;
  assign overflow    = r_overflow;

endmodule

// File: doc/rsb_ret_checker.md
RSB_RET_CHECKER -- requirements
Module: rsb_ret_checker

Interface
REQ-001 SHALL have parameter AMSB, default 79, meaning address MSB (80-bit IP).
REQ-002 SHALL have parameter DEPTH, default 8, meaning in-flight predicted-return entries (power of two).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port push_v  input  1  fetch queued a RET/JAL-via-LR with RSB prediction this cycle.
REQ-006 SHALL have port push_ra  input  AMSB+1  predicted return address taken from the RSB ra output.
REQ-007 SHALL have port res_v  input  1  oldest outstanding return resolved at execute.
REQ-008 SHALL have port res_target  input  AMSB+1  actual computed return target.
REQ-009 SHALL have port flush  input  1  external pipeline flush (older branch mispredict).
REQ-010 SHALL have port full  output  1  count==DEPTH.
REQ-011 SHALL have port empty  output  1  count==0.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  occupied entries.
REQ-013 SHALL have port mispredict  output  1  one-cycle pulse, RSB-predicted target wrong.
REQ-014 SHALL have port correct_ip  output  AMSB+1  redirect target, valid with mispredict.
REQ-015 SHALL have port stompedRets  output  3  discarded younger predicted returns, saturated at 7.
REQ-016 SHALL have port stompedRet  output  1  pulse, stompedRets!=0.
REQ-017 SHALL have port overflow  output  1  sticky, push attempted while full.

Function
REQ-018 SHALL hold predictions in a circular FIFO, head/tail pointers log2(DEPTH) bits, wrapping modulo DEPTH; count separate, DEPTH+1 values.
REQ-019 SHALL use FSM states RUN and RECOVER; reset enters RUN.
REQ-020 In RUN, push_v with !full SHALL write push_ra at tail and advance tail next edge.
REQ-021 push_v while full SHALL drop the entry, leave pointers unchanged, set overflow until reset.
REQ-022 In RUN, res_v with !empty SHALL compare res_target with head entry (full AMSB+1 bits) and pop head.
REQ-023 Match: no mispredict; count decrements, plus one if same-cycle push accepted.
REQ-024 Mismatch: SHALL register mispredict=1, correct_ip=res_target for exactly one cycle (1-cycle latency), clear FIFO (head=tail, count=0), enter RECOVER.
REQ-025 On mismatch, stompedRets SHALL equal min(7, entries remaining after pop + 1 if push_v same cycle); same-cycle push discarded, not stored.
REQ-026 res_v while empty SHALL be ignored: no pop, no mispredict.
REQ-027 flush SHALL clear FIFO, report stompedRets=min(7,count + push_v) with mispredict=0, enter RUN; flush wins over simultaneous res_v and push_v.
REQ-028 RECOVER SHALL last exactly one cycle, ignore push_v and res_v, then return to RUN.
REQ-029 stompedRet SHALL be asserted exactly when registered stompedRets!=0; both zero in all other cycles.
REQ-030 full, empty, count SHALL be registered and reflect state after the most recent edge.

Reset
REQ-031 Asserting rst SHALL immediately force: head=tail=0, count=0, empty=1, full=0, mispredict=0, correct_ip=0, stompedRets=0, stompedRet=0, overflow=0, state RUN.
REQ-032 Reset mid-operation SHALL discard all entries with no stomp report; FIFO storage need not be cleared.
REQ-033 Deassertion SHALL take effect at the next clk edge; first push accepted that edge.

Structure
REQ-034 Shared package SHALL hold the AMSB default, RSB DEPTH, stomp count width (3) and the FSM state enum.
REQ-035 Storage SHALL be one sub-module rsb_ret_fifo (push/pop/clear, count, full/empty); comparator, stomp counting and FSM in the top.
REQ-036 stompedRets/stompedRet SHALL connect directly to the RSB stompedRets/stompedRet inputs.

Verification
REQ-037 Push 0x...0105, 0x...0115; resolve 0x...0105 then 0x...0115 -> no mispredict, count 2->1->0, empty=1.
REQ-038 Push 0x...0105, 0x...010A, 0x...0120; resolve head with 0x...0200 -> mispredict pulse one cycle, correct_ip=0x...0200, stompedRets=2, stompedRet=1, count=0; push next cycle ignored (RECOVER).
REQ-039 Fill 8 entries, push ninth -> full=1, count=8, overflow=1 sticky; 8 matching resolves then empty=1, overflow still 1.
REQ-040 count=5, flush with push_v and res_v same cycle -> mispredict=0, stompedRets=6, count=0.
REQ-041 Head/tail wrap: 20 interleaved push/match-resolve pairs -> order preserved across wrap, no mispredict; res_v while empty -> no pulse.
REQ-042 count=3, assert rst asynchronously mid-cycle -> all outputs zero, empty=1 before next edge; after release push accepted, count=1.
